// File: rtl/apb3_master_pkg.sv
// Shared types for the APB3 master bridge: FSM state encoding and timeout counter sizing.
package apb3_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // A zero timeout still needs a one-bit counter so the vector stays legal.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb3_intf.sv
// APB3 bus bundle; the master modport lines up with the bridge's m_* ports.
interface apb3_intf #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/apb3_master_bridge.sv
// APB3 initiator fed by a valid/ready request; one transfer in flight, response 3 cycles after accept plus wait states.
// Backpressure: req_ready is high only in IDLE, so requests stall for the whole SETUP/ACCESS sequence.
module apb3_master_bridge
   import apb3_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  m_psel,
   output logic                  m_penable,
   output logic                  m_pwrite,
   output logic [ADDR_WIDTH-1:0] m_paddr,
   output logic [DATA_WIDTH-1:0] m_pwdata,
   input  logic [DATA_WIDTH-1:0] m_prdata,
   input  logic                  m_pready,
   input  logic                  m_pslverr
);

   localparam int unsigned   CW      = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES);
   localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

   apb_state_e            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_ready_d   = req_ready_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               pwrite_d    = req_write;
               paddr_d     = req_addr;
               pwdata_d    = req_wdata;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               req_ready_d = 1'b0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (m_pready) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : m_prdata;
               rsp_err_d   = m_pslverr;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end else if (TO_EN) begin
               // Counter stays at 0 when the timeout is disabled, so the bridge waits forever.
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_LIM) begin
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  req_ready_d   = 1'b1;
                  state_d       = IDLE;
               end
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign m_psel      = psel_q;
   assign m_penable   = penable_q;
   assign m_pwrite    = pwrite_q;
   assign m_paddr     = paddr_q;
   assign m_pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Scoreboard bench for apb3_master_bridge: directed requests push expected responses, a negedge monitor pops and compares.
// A bench-side APB slave model plays back the per-transfer wait count, read data and error flag.
module tb_apb3_master_bridge;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] slv_rdata;
      logic        slv_err;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
      int          exp_lat;
   } txn_t;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;

   apb3_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

   txn_t exp_q[$];
   int   acc_q[$];
   int   cyc = 0;
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   acc_cnt = 0;
   logic prev_psel = 1'b0;
   logic prev_pen  = 1'b0;

   apb3_master_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .m_psel     (apb.psel),
      .m_penable  (apb.penable),
      .m_pwrite   (apb.pwrite),
      .m_paddr    (apb.paddr),
      .m_pwdata   (apb.pwdata),
      .m_prdata   (apb.prdata),
      .m_pready   (apb.pready),
      .m_pslverr  (apb.pslverr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
   endtask

   // Slave model: holds PREADY low for 'waits' ACCESS cycles, toggling PSLVERR meanwhile.
   initial begin
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = '0;
      forever begin
         @(negedge clk);
         if (apb.psel && apb.penable && exp_q.size() > 0) begin
            if (acc_cnt >= exp_q[0].waits) begin
               apb.pready  = 1'b1;
               apb.prdata  = exp_q[0].slv_rdata;
               apb.pslverr = exp_q[0].slv_err;
            end else begin
               apb.pready  = 1'b0;
               apb.prdata  = 32'hBAD0_0000 | acc_cnt;
               apb.pslverr = (acc_cnt % 2 == 0);
            end
            acc_cnt++;
         end else begin
            apb.pready  = 1'b0;
            apb.pslverr = 1'b0;
            apb.prdata  = '0;
            acc_cnt     = 0;
         end
      end
   end

   // Monitor: records accepts, checks responses against the scoreboard and bus stability.
   always @(negedge clk) begin
      txn_t t;
      int   a;
      if (arst_n) begin
         if (req_valid && req_ready) acc_q.push_back(cyc);
         if (rsp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               fail_now("rsp_unexpected");
            end else begin
               t = exp_q.pop_front();
               a = acc_q.pop_front();
               check("rsp_rdata",   rsp_rdata, t.exp_rdata);
               check("rsp_err",     {31'd0, rsp_err}, {31'd0, t.exp_err});
               check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, t.exp_to});
               check("rsp_latency", cyc - a, t.exp_lat);
               check("psel_at_rsp",    {31'd0, apb.psel}, 32'd0);
               check("penable_at_rsp", {31'd0, apb.penable}, 32'd0);
               check("ready_at_rsp",   {31'd0, req_ready}, 32'd1);
            end
         end
         if (apb.psel) begin
            if (exp_q.size() == 0) begin
               fail_now("psel_without_request");
            end else begin
               check("paddr_stable",  apb.paddr, exp_q[0].addr);
               check("pwrite_stable", {31'd0, apb.pwrite}, {31'd0, exp_q[0].w});
               if (exp_q[0].w) check("pwdata_stable", apb.pwdata, exp_q[0].wdata);
            end
            if (!prev_psel) check("penable_in_setup", {31'd0, apb.penable}, 32'd0);
            else if (!prev_pen) check("penable_after_setup", {31'd0, apb.penable}, 32'd1);
         end
         prev_psel = apb.psel;
         prev_pen  = apb.penable;
      end else begin
         prev_psel = 1'b0;
         prev_pen  = 1'b0;
      end
   end

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                        input logic [31:0] srd, input logic serr, input logic [31:0] erd,
                        input logic eerr, input logic eto, input int lat, input bit keep,
                        output int acc);
      txn_t t;
      t.w = w; t.addr = a; t.wdata = d; t.waits = waits; t.slv_rdata = srd; t.slv_err = serr;
      t.exp_rdata = erd; t.exp_err = eerr; t.exp_to = eto; t.exp_lat = lat;
      exp_q.push_back(t);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            #1;
            acc = cyc - 1;
            break;
         end
      end
      if (acc < 0) fail_now("accept_timeout");
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         fail_now("response_timeout");
         exp_q.delete();
         acc_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a0, a1, a2;
      #3;
      check("reset_req_ready", {31'd0, req_ready}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_psel",      {31'd0, apb.psel}, 32'd0);
      check("reset_penable",   {31'd0, apb.penable}, 32'd0);
      check("reset_paddr",     apb.paddr, 32'd0);
      check("reset_pwdata",    apb.pwdata, 32'd0);
      check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
      @(negedge clk);
      #2 arst_n = 1'b1;
      #1 check("ready_before_edge", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 check("ready_after_edge", {31'd0, req_ready}, 32'd1);

      // zero-wait write, slave drives non-zero PRDATA that must not leak
      issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0,
            32'h0, 1'b0, 1'b0, 3, 1'b0, a0);
      wait_idle();
      // read with two wait states
      issue(1'b0, 32'h0000_0024, 32'h0, 2, 32'h1234_5678, 1'b0,
            32'h1234_5678, 1'b0, 1'b0, 5, 1'b0, a0);
      wait_idle();
      // slave error on a zero-wait read
      issue(1'b0, 32'h0000_0030, 32'h0, 0, 32'hA5A5_0001, 1'b1,
            32'hA5A5_0001, 1'b1, 1'b0, 3, 1'b0, a0);
      wait_idle();
      // PSLVERR toggles during three wait states but the final one is clean
      issue(1'b0, 32'h0000_0034, 32'h0, 3, 32'h0000_0042, 1'b0,
            32'h0000_0042, 1'b0, 1'b0, 6, 1'b0, a0);
      wait_idle();
      // stuck PREADY: timeout after 4 ACCESS cycles
      issue(1'b1, 32'h0000_0038, 32'h5555_AAAA, 1000, 32'h0, 1'b0,
            32'h0, 1'b1, 1'b1, 6, 1'b0, a0);
      wait_idle();
      issue(1'b0, 32'h0000_003C, 32'h0, 0, 32'hCAFE_F00D, 1'b0,
            32'hCAFE_F00D, 1'b0, 1'b0, 3, 1'b0, a0);
      wait_idle();

      // back-to-back writes with req_valid held high
      issue(1'b1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3, 1'b1, a0);
      issue(1'b1, 32'h0000_0004, 32'h2222_2222, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3, 1'b1, a1);
      issue(1'b1, 32'h0000_0008, 32'h3333_3333, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3, 1'b0, a2);
      check("b2b_spacing_1", a1 - a0, 32'd3);
      check("b2b_spacing_2", a2 - a1, 32'd3);
      wait_idle();

      // reset during ACCESS with PREADY low
      issue(1'b0, 32'h0000_0050, 32'h0, 1000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 6, 1'b0, a0);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_penable", {31'd0, apb.penable}, 32'd1);
      #2 arst_n = 1'b0;
      #1;
      check("abort_psel",      {31'd0, apb.psel}, 32'd0);
      check("abort_penable",   {31'd0, apb.penable}, 32'd0);
      check("abort_req_ready", {31'd0, req_ready}, 32'd0);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc_q.size() > 0) void'(acc_q.pop_front());
      @(negedge clk);
      @(negedge clk);
      check("held_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      #2 arst_n = 1'b1;
      #1 check("rel_ready_before_edge", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 check("rel_ready_after_edge", {31'd0, req_ready}, 32'd1);

      issue(1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4, 1'b0, a0);
      wait_idle();
      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
